// File: rtl/dffram_arbiter_pkg.sv
// Shared constants and types for the DFFRAM two-port arbiter.
// Byte-enable encodings, requester identifiers and the address-width helper live here.
package dffram_pkg;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

  typedef enum logic {
    PORT_P0 = 1'b0,
    PORT_P1 = 1'b1
  } port_e;

  // Each DFFRAM column holds 256 words, so extra columns add high address bits.
  function automatic int aw(input int cols);
    return 8 + $clog2(cols);
  endfunction

endpackage

// File: rtl/dffram_arbiter_if.sv
// Requester-side bus of the DFFRAM arbiter: request payload in, grant/read-data back.
// The master modport is the bus master's view and the slave modport is the arbiter's view.
interface dffram_arbiter_if #(
  parameter int AW = 8
);

  logic          REQ;
  logic [3:0]    WE;
  logic [AW-1:0] A;
  logic [31:0]   Di;
  logic          GNT;
  logic          RVALID;
  logic [31:0]   Do;

  modport master (
    output REQ,
    output WE,
    output A,
    output Di,
    input  GNT,
    input  RVALID,
    input  Do
  );

  modport slave (
    input  REQ,
    input  WE,
    input  A,
    input  Di,
    output GNT,
    output RVALID,
    output Do
  );

endinterface

// File: rtl/dffram_arbiter_rr_pick.sv
// Two-way request picker: a lone request always wins; a tie goes to P0 under fixed
// priority, otherwise to whichever port was not granted last.
module dffram_rr_pick
  import dffram_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (fixed || (last == PORT_P1)) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between two requesters, one access per clock.
// Grants are combinational; read data returns one cycle later with a per-port valid pulse.
module dffram_arbiter
  import dffram_pkg::*;
#(
  parameter int  COLS      = 1,
  parameter bit  FIXED_PRI = 1'b0,
  localparam int AW        = aw(COLS)
) (
  input  logic              CLK,
  input  logic              RESETn,
  dffram_arbiter_if.slave   P0,
  dffram_arbiter_if.slave   P1,
  output logic              RAM_EN,
  output logic [3:0]        RAM_WE,
  output logic [AW-1:0]     RAM_A,
  output logic [31:0]       RAM_Di,
  input  logic [31:0]       RAM_Do
);

  port_e         last_gnt;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic [1:0]    rvalid_q;
  logic [AW-1:0] hold_a;
  logic [31:0]   hold_di;

  dffram_rr_pick u_pick (
    .req   ({P1.REQ, P0.REQ}),
    .last  (last_gnt),
    .fixed (FIXED_PRI),
    .gnt   (pick)
  );

  // Reset gates the grant directly so nothing reaches the RAM while RESETn is low.
  always_comb begin
    gnt = RESETn ? pick : 2'b00;
  end

  // Idle cycles replay the last address/data so the RAM pins do not toggle.
  always_comb begin
    RAM_EN = 1'b0;
    RAM_WE = WE_READ;
    RAM_A  = hold_a;
    RAM_Di = hold_di;
    if (gnt[0]) begin
      RAM_EN = 1'b1;
      RAM_WE = P0.WE;
      RAM_A  = P0.A;
      RAM_Di = P0.Di;
    end else if (gnt[1]) begin
      RAM_EN = 1'b1;
      RAM_WE = P1.WE;
      RAM_A  = P1.A;
      RAM_Di = P1.Di;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_gnt <= PORT_P1;
      rvalid_q <= 2'b00;
      hold_a   <= '0;
      hold_di  <= '0;
    end else begin
      rvalid_q <= {gnt[1] && (P1.WE == WE_READ), gnt[0] && (P0.WE == WE_READ)};
      if (gnt[0]) begin
        last_gnt <= PORT_P0;
      end else if (gnt[1]) begin
        last_gnt <= PORT_P1;
      end
      if (RAM_EN) begin
        hold_a  <= RAM_A;
        hold_di <= RAM_Di;
      end
    end
  end

  assign P0.GNT    = gnt[0];
  assign P1.GNT    = gnt[1];
  assign P0.RVALID = rvalid_q[0];
  assign P1.RVALID = rvalid_q[1];
  assign P0.Do     = RAM_Do;
  assign P1.Do     = RAM_Do;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter: a behavioural DFFRAM, a round-robin instance and a
// fixed-priority instance sharing the same request stimulus, plus a byte-masked golden array.
module tb_dffram_arbiter;
  import dffram_pkg::*;

  localparam int AW    = aw(1);
  localparam int WORDS = 1 << AW;

  // Tie/priority sequence: {P1_REQ,P0_REQ}, expected {P1,P0} grants and read valids.
  localparam logic [1:0] T2_REQ  [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
  localparam logic [1:0] T2_GNT  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
  localparam logic [1:0] T2_RV   [6] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
  localparam logic [1:0] T2_FGNT [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 CLK = ~CLK;

  dffram_arbiter_if #(.AW(AW)) p0_if ();
  dffram_arbiter_if #(.AW(AW)) p1_if ();
  dffram_arbiter_if #(.AW(AW)) p0f_if ();
  dffram_arbiter_if #(.AW(AW)) p1f_if ();

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do;
  logic          ramf_en;
  logic [3:0]    ramf_we;
  logic [AW-1:0] ramf_a;
  logic [31:0]   ramf_di;

  logic [31:0] mem  [0:WORDS-1];
  logic [31:0] gold [0:WORDS-1];

  dffram_arbiter #(.COLS(1), .FIXED_PRI(1'b0)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .P0     (p0_if),
    .P1     (p1_if),
    .RAM_EN (ram_en),
    .RAM_WE (ram_we),
    .RAM_A  (ram_a),
    .RAM_Di (ram_di),
    .RAM_Do (ram_do)
  );

  dffram_arbiter #(.COLS(1), .FIXED_PRI(1'b1)) dut_fixed (
    .CLK    (CLK),
    .RESETn (RESETn),
    .P0     (p0f_if),
    .P1     (p1f_if),
    .RAM_EN (ramf_en),
    .RAM_WE (ramf_we),
    .RAM_A  (ramf_a),
    .RAM_Di (ramf_di),
    .RAM_Do (32'h0)
  );

  assign p0f_if.REQ = p0_if.REQ;
  assign p0f_if.WE  = p0_if.WE;
  assign p0f_if.A   = p0_if.A;
  assign p0f_if.Di  = p0_if.Di;
  assign p1f_if.REQ = p1_if.REQ;
  assign p1f_if.WE  = p1_if.WE;
  assign p1f_if.A   = p1_if.A;
  assign p1f_if.Di  = p1_if.Di;

  // Behavioural DFFRAM: byte-masked writes, registered read data.
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we == WE_READ) begin
        ram_do <= mem[ram_a];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end
      end
    end
  end

  task automatic applyStimulus(input bit port, input logic req, input logic [3:0] we,
                               input logic [AW-1:0] a, input logic [31:0] di);
    if (!port) begin
      p0_if.REQ = req; p0_if.WE = we; p0_if.A = a; p0_if.Di = di;
    end else begin
      p1_if.REQ = req; p1_if.WE = we; p1_if.A = a; p1_if.Di = di;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One single-port access: request, check its grant, complete on the edge, drop REQ.
  task automatic doAccess(input bit port, input logic [3:0] we, input logic [AW-1:0] a,
                          input logic [31:0] di);
    applyStimulus(port, 1'b1, we, a, di);
    @(negedge CLK);
    checkOutput($sformatf("gnt_p%0d_a%0d", port, a), port ? p1_if.GNT : p0_if.GNT, 32'd1);
    tick();
    applyStimulus(port, 1'b0, we, a, di);
    for (int b = 0; b < 4; b++) begin
      if (we[b]) gold[a][8*b +: 8] = di[8*b +: 8];
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  w;
    applyStimulus(1'b0, 1'b1, WE_READ, '0, '0);
    applyStimulus(1'b1, 1'b0, WE_READ, '0, '0);

    $display("[TB] reset state");
    @(negedge CLK);
    checkOutput("rst_p0_gnt", p0_if.GNT, 32'd0);
    checkOutput("rst_ram_en", ram_en, 32'd0);
    checkOutput("rst_p0_rvalid", p0_if.RVALID, 32'd0);
    checkOutput("rst_p1_rvalid", p1_if.RVALID, 32'd0);
    applyStimulus(1'b0, 1'b0, WE_READ, '0, '0);
    tick();
    RESETn = 1'b1;

    $display("[TB] P0 write then read");
    applyStimulus(1'b0, 1'b1, WE_WORD, 8'd5, 32'hDEADBEEF);
    @(negedge CLK);
    checkOutput("t1_wr_gnt", {p1_if.GNT, p0_if.GNT}, 32'd1);
    checkOutput("t1_ram_en", ram_en, 32'd1);
    checkOutput("t1_ram_we", ram_we, 32'hF);
    checkOutput("t1_ram_a", ram_a, 32'd5);
    checkOutput("t1_ram_di", ram_di, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b1, WE_READ, 8'd5, 32'h0);
    @(negedge CLK);
    checkOutput("t1_rd_gnt", p0_if.GNT, 32'd1);
    checkOutput("t1_wr_no_rvalid", p0_if.RVALID, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, WE_READ, 8'd5, 32'h0);
    @(negedge CLK);
    checkOutput("t1_rvalid", p0_if.RVALID, 32'd1);
    checkOutput("t1_do", p0_if.Do, 32'hDEADBEEF);
    checkOutput("t1_p1_rvalid", p1_if.RVALID, 32'd0);
    checkOutput("t1_idle_en", ram_en, 32'd0);
    checkOutput("t1_idle_we", ram_we, 32'd0);
    checkOutput("t1_idle_a_hold", ram_a, 32'd5);
    tick();
    @(negedge CLK);
    checkOutput("t1_rvalid_pulse", p0_if.RVALID, 32'd0);
    tick();

    $display("[TB] both ports requesting, round-robin and fixed priority");
    doAccess(1'b0, WE_WORD, 8'd1, 32'hA5A50001);
    doAccess(1'b1, WE_WORD, 8'd2, 32'h5A5A0002);
    applyStimulus(1'b0, 1'b0, WE_READ, 8'd1, 32'h0);
    applyStimulus(1'b1, 1'b0, WE_READ, 8'd2, 32'h0);
    for (int c = 0; c < 6; c++) begin
      p0_if.REQ = T2_REQ[c][0];
      p1_if.REQ = T2_REQ[c][1];
      @(negedge CLK);
      checkOutput($sformatf("t2_gnt_c%0d", c), {p1_if.GNT, p0_if.GNT}, 32'(T2_GNT[c]));
      checkOutput($sformatf("t2_rv_c%0d", c), {p1_if.RVALID, p0_if.RVALID}, 32'(T2_RV[c]));
      checkOutput($sformatf("t3_fgnt_c%0d", c), {p1f_if.GNT, p0f_if.GNT}, 32'(T2_FGNT[c]));
      if (T2_RV[c][0]) checkOutput($sformatf("t2_p0_do_c%0d", c), p0_if.Do, 32'hA5A50001);
      if (T2_RV[c][1]) checkOutput($sformatf("t2_p1_do_c%0d", c), p1_if.Do, 32'h5A5A0002);
      tick();
    end

    $display("[TB] P1 partial write");
    doAccess(1'b1, WE_WORD, 8'd7, 32'h11111111);
    doAccess(1'b1, 4'b0100, 8'd7, 32'h00AB0000);
    doAccess(1'b1, WE_READ, 8'd7, 32'h0);
    @(negedge CLK);
    checkOutput("t4_rvalid", p1_if.RVALID, 32'd1);
    checkOutput("t4_do", p1_if.Do, 32'h11AB1111);
    tick();

    $display("[TB] reset during a pending read");
    doAccess(1'b0, WE_READ, 8'd5, 32'h0);
    RESETn = 1'b0;
    applyStimulus(1'b0, 1'b1, WE_READ, 8'd5, 32'h0);
    applyStimulus(1'b1, 1'b1, WE_READ, 8'd2, 32'h0);
    @(negedge CLK);
    checkOutput("t5_squash_rvalid", p0_if.RVALID, 32'd0);
    checkOutput("t5_rst_gnt", {p1_if.GNT, p0_if.GNT}, 32'd0);
    checkOutput("t5_rst_en", ram_en, 32'd0);
    tick();
    RESETn = 1'b1;
    @(negedge CLK);
    checkOutput("t5_first_tie", {p1_if.GNT, p0_if.GNT}, 32'd1);
    checkOutput("t5_no_rvalid", {p1_if.RVALID, p0_if.RVALID}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, WE_READ, 8'd5, 32'h0);
    applyStimulus(1'b1, 1'b0, WE_READ, 8'd2, 32'h0);
    @(negedge CLK);
    checkOutput("t5_rvalid", {p1_if.RVALID, p0_if.RVALID}, 32'd1);
    checkOutput("t5_do", p0_if.Do, 32'hDEADBEEF);
    tick();

    $display("[TB] fill and read back every word");
    for (int i = 0; i < WORDS; i++) begin
      doAccess(1'(i % 2), WE_WORD, AW'(i), $urandom);
    end
    for (int i = 0; i < WORDS; i++) begin
      w = 4'($urandom_range(1, 15));
      d = $urandom;
      doAccess(1'((i + 1) % 2), w, AW'(i), d);
    end
    for (int i = 0; i < WORDS; i++) begin
      doAccess(1'(i % 2), WE_READ, AW'(i), 32'h0);
      @(negedge CLK);
      checkOutput($sformatf("t6_rv_%0d", i), (i % 2) ? p1_if.RVALID : p0_if.RVALID, 32'd1);
      checkOutput($sformatf("t6_do_%0d", i), (i % 2) ? p1_if.Do : p0_if.Do, gold[i]);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
